// File: rtl/me_mem_loader_if.sv
// Pixel stream handshake between the pixel source and the on-chip buffer loader.
interface me_mem_loader_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/me_mem_loader.sv
// Streams a raw pixel sequence into the template-block RAM (first) and the
// search-window RAM (second), generating write strobes, addresses and data,
// and pulses done when the last window pixel is written.
module me_mem_loader #(
  parameter int DATA_W = 8,
  parameter int TB_AW  = 6,
  parameter int SW_AW  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr,
  me_mem_loader_if.slave    s,
  output logic              tb_we,
  output logic [TB_AW-1:0]  tb_waddr,
  output logic              sw_we,
  output logic [SW_AW-1:0]  sw_waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_TB = 2'd1,
    LOAD_SW = 2'd2
  } state_t;

  localparam logic [TB_AW-1:0] TB_LAST = '1;
  localparam logic [SW_AW-1:0] SW_LAST = '1;

  state_t             state_q, state_d;
  logic [TB_AW-1:0]   tb_cnt;
  logic [SW_AW-1:0]   sw_cnt;
  logic               ready;
  logic               tb_wr, sw_wr, fin;
  logic               cnt_zero;

  assign s.in_ready = ready;
  assign busy       = (state_q != IDLE);
  assign cnt_zero   = clr || (state_q == IDLE && start);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, ready decode and beat acceptance; clr overrides everything
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    tb_wr   = 1'b0;
    sw_wr   = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_TB;
      end
      LOAD_TB: begin
        ready = 1'b1;
        tb_wr = s.in_valid;
        if (tb_wr && tb_cnt == TB_LAST) state_d = LOAD_SW;
      end
      LOAD_SW: begin
        ready = 1'b1;
        sw_wr = s.in_valid;
        if (sw_wr && sw_cnt == SW_LAST) begin
          state_d = IDLE;
          fin     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d = IDLE;
      tb_wr   = 1'b0;
      sw_wr   = 1'b0;
      fin     = 1'b0;
    end
  end

  // Pixel counters: cleared at load start or abort, held at their last
  // value on the final beat so they never wrap inside a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_cnt <= '0;
      sw_cnt <= '0;
    end else if (cnt_zero) begin
      tb_cnt <= '0;
      sw_cnt <= '0;
    end else begin
      if (tb_wr && tb_cnt != TB_LAST) tb_cnt <= tb_cnt + 1'b1;
      if (sw_wr && sw_cnt != SW_LAST) sw_cnt <= sw_cnt + 1'b1;
    end
  end

  // Registered write port: strobes for one cycle, address/data held otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tb_we    <= 1'b0;
      sw_we    <= 1'b0;
      tb_waddr <= '0;
      sw_waddr <= '0;
      wdata    <= '0;
      done     <= 1'b0;
    end else begin
      tb_we <= tb_wr;
      sw_we <= sw_wr;
      done  <= fin;
      if (tb_wr)          tb_waddr <= tb_cnt;
      if (sw_wr)          sw_waddr <= sw_cnt;
      if (tb_wr || sw_wr) wdata    <= s.in_data;
    end
  end

endmodule

// File: doc/me_mem_loader.md
# me_mem_loader

Write-side counterpart of the search-window/template-block read address generator. It accepts a raw pixel stream over a valid/ready handshake and writes it into the two on-chip buffers: first the full template block (64 pixels), then the full search window (1024 pixels). It produces the write addresses, write enables and write data for both RAMs, and reports completion so the motion-estimation controller can start a read/SAD pass.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- TB_AW, 6, template-block address width; the block holds 2**TB_AW pixels
- SW_AW, 10, search-window address width; the window holds 2**SW_AW pixels

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  begins a load; sampled only in IDLE
- clr  input  1  synchronous abort; returns the block to IDLE
- in_valid  input  1  in_data holds a pixel
- in_data  input  DATA_W  pixel, raster order: template block first, then search window
- in_ready  output  1  loader can accept a pixel
- tb_we  output  1  template-block RAM write strobe
- tb_waddr  output  TB_AW  template-block write address
- sw_we  output  1  search-window RAM write strobe
- sw_waddr  output  SW_AW  search-window write address
- wdata  output  DATA_W  write data, shared by both RAMs
- busy  output  1  high in LOAD_TB and LOAD_SW
- done  output  1  one-cycle pulse, load complete

## Operation
- States are IDLE, LOAD_TB and LOAD_SW.
- IDLE: in_ready=0. If start=1 and clr=0, go to LOAD_TB and zero both internal counters.
- LOAD_TB: in_ready=1. A beat is accepted when in_valid=1 and in_ready=1.
  - Each accepted beat writes to address tb_cnt, then tb_cnt increments.
  - The beat at tb_cnt = 2**TB_AW-1 is the last one; after it, go to LOAD_SW.
- LOAD_SW: behaves the same way using sw_cnt. After the beat at sw_cnt = 2**SW_AW-1, go to IDLE and set done=1.
- Counters never wrap inside a load. The state changes on the same edge that would otherwise wrap the counter.
- in_ready is decoded combinationally from state only. It does not depend on in_valid.
- start outside IDLE is ignored.
- clr has priority over everything:
  - next state is IDLE and both counters are zeroed;
  - no write strobe is produced for a beat presented in the clr cycle;
  - no done is produced.
- If start and clr are high in the same cycle, clr wins.
- Write outputs are registered from the accepted beat:
  - tb_we or sw_we = 1 for exactly one cycle per accepted beat;
  - tb_waddr/sw_waddr = counter value at acceptance;
  - wdata = in_data at acceptance.
- tb_we and sw_we are never high in the same cycle.
- Address and data outputs hold their last value when the strobe is low.

## Timing
- Reset values: state=IDLE, in_ready=0, tb_we=0, sw_we=0, tb_waddr=0, sw_waddr=0, wdata=0, busy=0, done=0, counters=0.
- Reset mid-load abandons the load immediately. No done is produced.
- start is sampled at edge E: busy=1 and in_ready=1 from E+1.
- Write latency is 1 cycle: a beat accepted at edge N shows its strobe, address and data during cycle N+1.
- Back-to-back beats give one write per cycle. A full load takes 1088 accepted beats, i.e. a minimum of 1088 cycles from the first accept.
- done is registered and is asserted in the same cycle as the final sw_we (address 1023).
- busy and in_ready drop in that same cycle.
- The earliest restart is the cycle in which done=1: start may be asserted then, and LOAD_TB begins on the next edge.
- in_valid may drop at any time. Stalls insert no writes and cause no counter change.

## Test plan
- Reset, then start, then 1088 back-to-back beats with data = index mod 256 -> tb_we for addresses 0..63 with data 0..63; then sw_we for addresses 0..1023 with data 64..(1087 mod 256); exactly one done pulse, coincident with sw_waddr=1023.
- Same load with in_valid toggling randomly at about 50% -> identical write sequence, no duplicate or skipped address, done after the 1088th accepted beat.
- Boundary: last template beat (tb_waddr=63) followed directly by the first window beat -> tb_we then sw_we on consecutive cycles with sw_waddr=0, never both high together.
- clr asserted after 100 accepted beats with in_valid=1 -> no write for that beat, busy=0 and in_ready=0 next cycle, no done; a new start reloads from tb_waddr=0.
- rst pulsed mid-window (sw_cnt=500) -> all outputs return to their reset values asynchronously; start plus a full load afterwards completes normally.
- start pulsed during LOAD_SW, and start+clr together in IDLE -> no effect in both cases: the load continues uninterrupted, and IDLE is held.
